// File: rtl/servo_pkg.sv
// servo_pkg
// Shared definitions for the servo_bank slice: the width-sequencer state
// type and helper functions that turn clock/timing parameters into cycle
// counts and register widths.
// Ports: none (package).

package servo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Clock cycles in one PWM frame.
    function automatic int frame_cycles(input int fclk, input int frame_hz);
        return fclk / frame_hz;
    endfunction

    // Microseconds to clock cycles. Dividing first keeps the intermediate
    // inside 32 bits for MHz-multiple clocks.
    function automatic int us_to_cycles(input int fclk, input int us);
        return (fclk / 1_000_000) * us;
    endfunction

    // Bits needed to hold the values 0..max_value.
    function automatic int bits_for(input int max_value);
        if (max_value < 2) begin
            return 1;
        end
        return $clog2(max_value + 1);
    endfunction

    // Bits needed to index count entries (never less than one).
    function automatic int index_bits(input int count);
        if (count < 3) begin
            return 1;
        end
        return $clog2(count);
    endfunction

endpackage

// File: rtl/servo_bank_level.sv
// servo_level
// Per-channel attack/decay smoother. A new magnitude at or above the
// current level is taken immediately; a lower one pulls the level down by
// a fraction of the gap (at least one count), so the level never drops
// below the magnitude that caused the decay.
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   mag_i       in   MAG_W  magnitude for this channel
//   mag_valid_i in   1      magnitude strobe
//   lvl_o       out  MAG_W  smoothed level

module servo_level
    import servo_pkg::*;
#(
    parameter int MAG_W       = 13,
    parameter int DECAY_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MAG_W-1:0] mag_i,
    input  logic             mag_valid_i,
    output logic [MAG_W-1:0] lvl_o
);

    logic [MAG_W-1:0] lvl_q;
    logic [MAG_W-1:0] lvl_d;
    logic [MAG_W-1:0] gap;
    logic [MAG_W-1:0] step;

    // Next level. The gap is only meaningful when mag_i < lvl_q; a step of
    // zero is bumped to one so small gaps still close.
    always_comb begin
        lvl_d = lvl_q;
        gap   = lvl_q - mag_i;
        step  = gap >> DECAY_SHIFT;
        if (step == '0) begin
            step = MAG_W'(1);
        end
        if (mag_valid_i) begin
            if (mag_i >= lvl_q) begin
                lvl_d = mag_i;
            end else begin
                lvl_d = lvl_q - step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= '0;
        end else begin
            lvl_q <= lvl_d;
        end
    end

    assign lvl_o = lvl_q;

endmodule

// File: rtl/servo_bank.sv
// servo_bank
// N-channel hobby-servo PWM driver fed by FFT bin magnitudes. One frame
// counter drives all channels; per-channel smoothed levels are snapshotted
// once per frame, converted to pulse widths by a single time-shared
// multiplier, and held in shadow registers that are promoted to the active
// widths (together with the channel enables) only at the frame boundary.
// Ports:
//   FPGA_CLK1_50  in   1              clock
//   reset_n       in   1              asynchronous active-low reset
//   mag           in   MAG_W x NBINS  bin magnitudes, channel i uses bin i
//   mag_valid     in   1              strobe: mag holds a new frame
//   ch_en         in   NCH            per-channel enable, taken at frame wrap
//   servo_pulse   out  NCH            registered PWM outputs
//   frame_start   out  1              high for the cycle frame_cnt == 0

module servo_bank
    import servo_pkg::*;
#(
    parameter int FCLK         = 50_000_000,
    parameter int FRAME_HZ     = 50,
    parameter int NCH          = 5,
    parameter int NBINS        = 8,
    parameter int MAG_W        = 13,
    parameter int PULSE_MIN_US = 1000,
    parameter int PULSE_MAX_US = 2000,
    parameter int DECAY_SHIFT  = 4
) (
    input  logic             FPGA_CLK1_50,
    input  logic             reset_n,
    input  logic [MAG_W-1:0] mag [0:NBINS-1],
    input  logic             mag_valid,
    input  logic [NCH-1:0]   ch_en,
    output logic [NCH-1:0]   servo_pulse,
    output logic             frame_start
);

    localparam int FRAME_CYC = frame_cycles(FCLK, FRAME_HZ);
    localparam int MIN_CYC   = us_to_cycles(FCLK, PULSE_MIN_US);
    localparam int MAX_CYC   = us_to_cycles(FCLK, PULSE_MAX_US);
    localparam int SPAN_CYC  = MAX_CYC - MIN_CYC;

    localparam int CNT_W  = bits_for(FRAME_CYC - 1);
    localparam int W_W    = bits_for(MAX_CYC);
    localparam int SPAN_W = bits_for(SPAN_CYC);
    localparam int PROD_W = MAG_W + SPAN_W;
    localparam int IDX_W  = index_bits(NCH);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_SNAP = CNT_W'(MAX_CYC);
    localparam logic [W_W-1:0]    W_MIN    = W_W'(MIN_CYC);
    localparam logic [PROD_W-1:0] SPAN_P   = PROD_W'(SPAN_CYC);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NCH - 1);

    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] frame_cnt_d;
    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [IDX_W-1:0] ch_idx_q;
    logic [IDX_W-1:0] ch_idx_d;
    logic [MAG_W-1:0] snap_q     [NCH];
    logic [MAG_W-1:0] snap_d     [NCH];
    logic [W_W-1:0]   shadow_w_q [NCH];
    logic [W_W-1:0]   shadow_w_d [NCH];
    logic [W_W-1:0]   active_w_q [NCH];
    logic [W_W-1:0]   active_w_d [NCH];
    logic [NCH-1:0]   en_act_q;
    logic [NCH-1:0]   en_act_d;
    logic [NCH-1:0]   servo_pulse_q;
    logic [NCH-1:0]   servo_pulse_d;
    logic             frame_start_q;
    logic             frame_start_d;

    logic [MAG_W-1:0]  lvl [NCH];
    logic              frame_wrap;
    logic              snap_now;
    logic [PROD_W-1:0] prod;
    logic [W_W-1:0]    calc_w;
    logic              unused_bins;

    // One smoother per channel; bins beyond NCH are ignored.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        servo_level #(
            .MAG_W       (MAG_W),
            .DECAY_SHIFT (DECAY_SHIFT)
        ) u_level (
            .clk         (FPGA_CLK1_50),
            .rst_n       (reset_n),
            .mag_i       (mag[g]),
            .mag_valid_i (mag_valid),
            .lvl_o       (lvl[g])
        );
    end

    always_comb begin
        unused_bins = 1'b0;
        for (int b = NCH; b < NBINS; b++) begin
            unused_bins = unused_bins ^ (^mag[b]);
        end
    end

    // Frame counter and the two instants the rest of the design keys on.
    always_comb begin
        frame_wrap  = (frame_cnt_q == CNT_LAST);
        snap_now    = (frame_cnt_q == CNT_SNAP);
        frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + 1'b1;
    end

    // Shared multiplier: scale the snapshot of the channel currently being
    // converted. The result cannot exceed MAX_CYC, so no saturation.
    always_comb begin
        prod   = PROD_W'(snap_q[ch_idx_q]) * SPAN_P;
        calc_w = W_MIN + W_W'(prod >> MAG_W);
    end

    // Width sequencer. The snapshot is taken from the registered levels, so
    // a strobe in the snapshot cycle or during CALC does not leak into this
    // frame's conversion. CALC walks one channel per cycle.
    always_comb begin
        state_d    = state_q;
        ch_idx_d   = ch_idx_q;
        snap_d     = snap_q;
        shadow_w_d = shadow_w_q;
        unique case (state_q)
            IDLE: begin
                if (snap_now) begin
                    snap_d   = lvl;
                    ch_idx_d = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                shadow_w_d[ch_idx_q] = calc_w;
                if (ch_idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    ch_idx_d = ch_idx_q + 1'b1;
                end
            end
            DONE: begin
                if (frame_wrap) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame-boundary promotion and output compare. Widths and enables only
    // change at the wrap, so a pulse in progress always runs to completion.
    always_comb begin
        active_w_d = active_w_q;
        en_act_d   = en_act_q;
        if (frame_wrap) begin
            active_w_d = shadow_w_q;
            en_act_d   = ch_en;
        end
        for (int i = 0; i < NCH; i++) begin
            servo_pulse_d[i] = en_act_q[i] && (frame_cnt_q < CNT_W'(active_w_q[i]));
        end
        frame_start_d = (frame_cnt_d == '0);
    end

    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q   <= '0;
            state_q       <= IDLE;
            ch_idx_q      <= '0;
            en_act_q      <= '0;
            servo_pulse_q <= '0;
            frame_start_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                snap_q[i]     <= '0;
                shadow_w_q[i] <= W_MIN;
                active_w_q[i] <= W_MIN;
            end
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            state_q       <= state_d;
            ch_idx_q      <= ch_idx_d;
            en_act_q      <= en_act_d;
            servo_pulse_q <= servo_pulse_d;
            frame_start_q <= frame_start_d;
            snap_q        <= snap_d;
            shadow_w_q    <= shadow_w_d;
            active_w_q    <= active_w_d;
        end
    end

    assign servo_pulse = servo_pulse_q;
    assign frame_start = frame_start_q;

endmodule
